ddr_frame_reader: RTL and testbench
===================================

Name: ddr_frame_reader

Overview:
- AXI read master on the DDR clock that fetches one display frame from a DDR frame buffer.
- Fetches in 16-beat bursts and pushes each 256-bit beat into the downstream read buffer that feeds VESA output.
- Read-side counterpart of the AXI write interconnect: it consumes the frame layout the writer produces.
- Burst issue is gated by downstream buffer room, so the read data channel never stalls.

Parameters:
- CTRL_ADDR_WIDTH, 28, DDR controller address width.
- MEM_DQ_WIDTH, 32, DDR DQ width; AXI data width is MEM_DQ_WIDTH*8.
- FRAME_WORDS, 32400, 256-bit words per frame (960*540*16/256); any value >= 1.
- BURST_BEATS, 16, maximum beats per burst; arlen = beats-1.
- ADDR_STEP, 8, address increment per beat (MEM_DQ_WIDTH*8/32 DQ words).
- RD_ID, 4'd1, value driven on axi_arid and expected on axi_rid.

Ports:
- clk  in  1  DDR user clock.
- rst  in  1  synchronous, active-low reset.
- init_done  in  1  DDR calibration complete; no address issued while low.
- frame_start  in  1  single-cycle pulse, already synchronous to clk; begins a frame read.
- frame_base  in  CTRL_ADDR_WIDTH  start address of the frame; sampled on accepted frame_start.
- buf_room  in  1  downstream buffer can accept BURST_BEATS more words.
- axi_araddr  out  CTRL_ADDR_WIDTH  burst start address.
- axi_arid  out  4  constant RD_ID.
- axi_arlen  out  4  beats-1.
- axi_arsize  out  3  constant 3'b101 (32 bytes).
- axi_arburst  out  2  constant 2'b01 (INCR).
- axi_arvalid  out  1  address valid.
- axi_arready  in  1  address accepted.
- axi_rready  out  1  read data ready.
- axi_rdata  in  MEM_DQ_WIDTH*8  read data.
- axi_rvalid  in  1  read data valid.
- axi_rlast  in  1  last beat of burst.
- axi_rid  in  4  read ID.
- buf_wr_en  out  1  write strobe to downstream buffer.
- buf_wr_data  out  MEM_DQ_WIDTH*8  registered copy of axi_rdata.
- frame_busy  out  1  high from accepted frame_start until frame_done.
- frame_done  out  1  one-cycle pulse after the final beat of a frame.
- rd_err  out  1  sticky; rid mismatch or beat-count error; cleared only by reset.

Behaviour:
- Reset (rst=0 at a clk edge): all outputs 0, except the constant axi_arid/arsize/arburst. State IDLE; counters 0.
- States:
  - IDLE: frame_start && init_done -> ADDR; latch frame_base; words_left=FRAME_WORDS.
  - ADDR: assert arvalid once buf_room=1 (checked on ADDR entry and each cycle until asserted).
    - araddr = current address; arlen = min(words_left,BURST_BEATS)-1.
    - araddr/arlen/arvalid hold stable until arready; arvalid never drops before arready.
    - On arready -> DATA.
  - DATA: rready=1 throughout. Each rvalid beat:
    - buf_wr_en=1 next cycle (1-cycle latency), buf_wr_data=rdata.
    - beat counter increments.
  - End of burst, on beat with rlast=1:
    - address += beats*ADDR_STEP; words_left -= beats.
    - words_left==0 -> DONE; else -> ADDR.
  - DONE: frame_done=1 for one cycle; frame_busy falls the same cycle -> IDLE.
- Beat-count check: rlast arriving early or late versus the beat counter sets rd_err. The burst still closes on rlast.
- rid != RD_ID: beat is discarded (no buf_wr_en) and rd_err is set.
- frame_start while busy:
  - Recorded as a pending restart.
  - The in-flight burst completes, with its data still written.
  - Then jump to ADDR with the new frame_base and words_left=FRAME_WORDS.
  - No frame_done is issued for the aborted frame.
- frame_start while init_done=0: ignored.
- Final burst: when FRAME_WORDS is not a multiple of BURST_BEATS, the final burst is short (arlen = remainder-1).
- Address arithmetic is modulo 2^CTRL_ADDR_WIDTH (wraps silently).
- Only one outstanding burst at any time.

Optional Feature:
- FRAME_RD_TIMEOUT_EN defined:
  - 10-bit watchdog counts DATA-state cycles without rvalid.
  - At 1023: set rd_err, assert frame_done, return to IDLE; later stray beats are ignored.
- Not defined: no watchdog; DATA waits indefinitely.

Test Plan:
- FRAME_WORDS=40, frame_base=0x100, buf_room=1, 0-wait slave -> three bursts:
  - (araddr 0x100, arlen 15), (0x180, 15), (0x200, 7).
  - 40 buf_wr_en pulses, each 1 cycle after its rvalid; one frame_done.
- buf_room=0 for 50 cycles after frame_start -> arvalid stays 0; arvalid rises within 1 cycle of buf_room=1.
- arready held low 20 cycles -> araddr/arlen/arvalid constant throughout; exactly one burst accepted.
- frame_start (base 0x4000) mid-burst 2 -> burst 2 completes (16 writes), next araddr=0x4000, frame_done only after the full new frame.
- Slave returns rid=4'd3 on beat 5 -> rd_err=1, 15 writes for that burst, rd_err stays high until rst=0.
- FRAME_RD_TIMEOUT_EN, slave stops after 4 beats -> rd_err and frame_done 1023 cycles after the last rvalid, state IDLE.

Source files
------------

// File: rtl/ddr_frame_reader_if.sv
// AXI read-channel bundle between the frame reader (master) and the DDR controller (slave).
`timescale 1ns/1ps
interface ddr_frame_reader_if #(
    parameter int CTRL_ADDR_WIDTH = 28,
    parameter int MEM_DQ_WIDTH    = 32
);
    logic [CTRL_ADDR_WIDTH-1:0] axi_araddr;
    logic [3:0]                 axi_arid;
    logic [3:0]                 axi_arlen;
    logic [2:0]                 axi_arsize;
    logic [1:0]                 axi_arburst;
    logic                       axi_arvalid;
    logic                       axi_arready;
    logic                       axi_rready;
    logic [MEM_DQ_WIDTH*8-1:0]  axi_rdata;
    logic                       axi_rvalid;
    logic                       axi_rlast;
    logic [3:0]                 axi_rid;

    modport master (
        output axi_araddr, axi_arid, axi_arlen, axi_arsize, axi_arburst, axi_arvalid, axi_rready,
        input  axi_arready, axi_rdata, axi_rvalid, axi_rlast, axi_rid
    );

    modport slave (
        input  axi_araddr, axi_arid, axi_arlen, axi_arsize, axi_arburst, axi_arvalid, axi_rready,
        output axi_arready, axi_rdata, axi_rvalid, axi_rlast, axi_rid
    );
endinterface

// File: rtl/ddr_frame_reader.sv
// Fetches one frame from DDR in room-gated bursts and streams the beats to the read buffer.
// Optional read watchdog enabled by defining FRAME_RD_TIMEOUT_EN.
`timescale 1ns/1ps
module ddr_frame_reader #(
    parameter int         CTRL_ADDR_WIDTH = 28,
    parameter int         MEM_DQ_WIDTH    = 32,
    parameter int         FRAME_WORDS     = 32400,
    parameter int         BURST_BEATS     = 16,
    parameter int         ADDR_STEP       = 8,
    parameter logic [3:0] RD_ID           = 4'd1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       init_done,
    input  logic                       frame_start,
    input  logic [CTRL_ADDR_WIDTH-1:0] frame_base,
    input  logic                       buf_room,
    ddr_frame_reader_if.master         axi,
    output logic                       buf_wr_en,
    output logic [MEM_DQ_WIDTH*8-1:0]  buf_wr_data,
    output logic                       frame_busy,
    output logic                       frame_done,
    output logic                       rd_err
);
    localparam int WL_W = $clog2(FRAME_WORDS + 1);
    localparam int BB_W = $clog2(BURST_BEATS + 1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    state_t                     state, state_nxt;
    logic [CTRL_ADDR_WIDTH-1:0] addr, pend_base, araddr;
    logic [WL_W-1:0]            words_left, words_after;
    logic [BB_W-1:0]            burst_beats, beat_cnt, beat_nxt, beats_cur;
    logic [3:0]                 arlen;
    logic                       arvalid, pend;
    logic                       start_ok, req, beat, burst_end, rid_bad, err_evt, timeout;
    logic [CTRL_ADDR_WIDTH-1:0] req_base, addr_inc;

    assign start_ok    = frame_start & init_done;
    // A restart request is either already pending or arriving this very cycle.
    assign req         = pend | start_ok;
    assign req_base    = start_ok ? frame_base : pend_base;
    assign beat        = (state == DATA) & axi.axi_rvalid;
    assign burst_end   = beat & axi.axi_rlast;
    assign rid_bad     = axi.axi_rid != RD_ID;
    assign beat_nxt    = beat_cnt + BB_W'(1);
    assign beats_cur   = (int'(words_left) < BURST_BEATS) ? BB_W'(words_left) : BB_W'(BURST_BEATS);
    assign words_after = words_left - WL_W'(burst_beats);
    assign addr_inc    = CTRL_ADDR_WIDTH'(int'(burst_beats) * ADDR_STEP);
    assign err_evt     = (beat & (rid_bad
                                  | (axi.axi_rlast & (beat_nxt != burst_beats))
                                  | (~axi.axi_rlast & (beat_nxt >= burst_beats))))
                         | timeout;

`ifdef FRAME_RD_TIMEOUT_EN
    logic [9:0] wdog;
    always_ff @(posedge clk) begin
        if (!rst || state != DATA || axi.axi_rvalid)
            wdog <= '0;
        else if (wdog != 10'h3FF)
            wdog <= wdog + 10'd1;
    end
    assign timeout = (state == DATA) & ~axi.axi_rvalid & (wdog == 10'h3FF);
`else
    assign timeout = 1'b0;
`endif

    assign axi.axi_araddr  = araddr;
    assign axi.axi_arid    = RD_ID;
    assign axi.axi_arlen   = arlen;
    assign axi.axi_arsize  = 3'b101;
    assign axi.axi_arburst = 2'b01;
    assign axi.axi_arvalid = arvalid;
    assign axi.axi_rready  = (state == DATA);
    assign frame_busy      = (state == ADDR) | (state == DATA);
    assign frame_done      = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start_ok) state_nxt = ADDR;
            ADDR: if (arvalid && axi.axi_arready) state_nxt = DATA;
            DATA: begin
                if (burst_end)
                    state_nxt = (req || words_after != '0) ? ADDR : DONE;
                else if (timeout)
                    state_nxt = DONE;
            end
            DONE: state_nxt = start_ok ? ADDR : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Burst bookkeeping, address issue and the one-cycle write stage to the buffer
    always_ff @(posedge clk) begin
        if (!rst) begin
            arvalid     <= 1'b0;
            araddr      <= '0;
            arlen       <= '0;
            buf_wr_en   <= 1'b0;
            buf_wr_data <= '0;
            rd_err      <= 1'b0;
            pend        <= 1'b0;
            beat_cnt    <= '0;
            burst_beats <= '0;
            words_left  <= '0;
        end else begin
            buf_wr_en <= beat & ~rid_bad;
            if (beat) buf_wr_data <= axi.axi_rdata;
            if (err_evt) rd_err <= 1'b1;
            if (start_ok) begin
                pend      <= 1'b1;
                pend_base <= frame_base;
            end
            unique case (state)
                IDLE, DONE: begin
                    if (start_ok) begin
                        addr       <= frame_base;
                        words_left <= WL_W'(FRAME_WORDS);
                        pend       <= 1'b0;
                    end
                end
                ADDR: begin
                    if (!arvalid) begin
                        // Nothing in flight yet, so a restart can take effect immediately.
                        if (req) begin
                            addr       <= req_base;
                            words_left <= WL_W'(FRAME_WORDS);
                            pend       <= 1'b0;
                        end else if (buf_room) begin
                            arvalid     <= 1'b1;
                            araddr      <= addr;
                            arlen       <= 4'(beats_cur - BB_W'(1));
                            burst_beats <= beats_cur;
                        end
                    end else if (axi.axi_arready) begin
                        arvalid  <= 1'b0;
                        beat_cnt <= '0;
                    end
                end
                DATA: begin
                    if (beat) beat_cnt <= beat_nxt;
                    if (burst_end) begin
                        if (req) begin
                            addr       <= req_base;
                            words_left <= WL_W'(FRAME_WORDS);
                            pend       <= 1'b0;
                        end else begin
                            addr       <= addr + addr_inc;
                            words_left <= words_after;
                        end
                    end
                    if (timeout) pend <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ddr_frame_reader.sv
// Randomized bench for ddr_frame_reader against a burst/beat-level reference model of the frame layout.
`timescale 1ns/1ps
module tb_ddr_frame_reader;
    localparam int AW = 28, DQ = 32, DW = 256, FW = 40, BB = 16, STEP = 8;

    logic          clk = 1'b0, rst = 1'b0, init_done = 1'b0, frame_start = 1'b0, buf_room = 1'b1;
    logic [AW-1:0] frame_base = '0;
    logic          buf_wr_en, frame_busy, frame_done, rd_err;
    logic [DW-1:0] buf_wr_data;

    ddr_frame_reader_if #(.CTRL_ADDR_WIDTH(AW), .MEM_DQ_WIDTH(DQ)) axi ();

    ddr_frame_reader #(
        .CTRL_ADDR_WIDTH(AW), .MEM_DQ_WIDTH(DQ), .FRAME_WORDS(FW),
        .BURST_BEATS(BB), .ADDR_STEP(STEP), .RD_ID(4'd1)
    ) dut (
        .clk(clk), .rst(rst), .init_done(init_done), .frame_start(frame_start),
        .frame_base(frame_base), .buf_room(buf_room), .axi(axi),
        .buf_wr_en(buf_wr_en), .buf_wr_data(buf_wr_data), .frame_busy(frame_busy),
        .frame_done(frame_done), .rd_err(rd_err)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: expected address requests and the expected buffer write stream.
    typedef struct packed { logic [AW-1:0] addr; logic [3:0] len; } ar_t;
    typedef struct { logic [AW-1:0] addr; int nb; int num; } sb_t;
    ar_t           exp_ar[$];
    logic [DW-1:0] exp_data[$];
    sb_t           sq[$];

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        logic [DW-1:0] w;
        for (int i = 0; i < 8; i++) w[i*32 +: 32] = {i[3:0], a} ^ 32'h5A5A_0000;
        return w;
    endfunction

    task automatic model_frame(input logic [AW-1:0] base);
        int left = FW;
        logic [AW-1:0] a = base;
        while (left > 0) begin
            int n = (left < BB) ? left : BB;
            exp_ar.push_back('{a, 4'(n - 1)});
            a = a + AW'(n * STEP);
            left -= n;
        end
    endtask

    int   ar_cnt = 0, wr_cnt = 0, done_cnt = 0, bad_burst = -1, ar_hold = 0, beat = 0, nb;
    bit   early = 0, gaps = 0, ar_rand = 0;
    logic l_arvalid = 0, l_arready = 0, l_rvalid = 0, l_rready = 0, exp_wr;
    logic [3:0]    l_rid = 4'd1, l_arlen = '0;
    logic [AW-1:0] l_araddr = '0;
    ar_t  e;
    sb_t  s;

    // Slave and monitor: everything at the falling edge, looking back at the last rising edge.
    initial begin
        axi.axi_arready = 1'b0; axi.axi_rvalid = 1'b0; axi.axi_rlast = 1'b0;
        axi.axi_rdata = '0; axi.axi_rid = 4'd1;
        forever begin
            @(negedge clk);
            if (!rst) begin
                sq.delete(); beat = 0;
                l_arvalid = 0; l_arready = 0; l_rvalid = 0; l_rready = 0;
                axi.axi_arready = 1'b0; axi.axi_rvalid = 1'b0; axi.axi_rlast = 1'b0;
                continue;
            end
            if (l_arvalid && l_arready) begin
                ar_cnt++;
                chk("ar_expected", exp_ar.size() != 0, 1);
                if (exp_ar.size() != 0) begin
                    e = exp_ar.pop_front();
                    chk("araddr", l_araddr, e.addr);
                    chk("arlen", l_arlen, e.len);
                    nb = early ? int'(e.len) : int'(e.len) + 1;
                    for (int i = 0; i < nb; i++)
                        if (!(ar_cnt - 1 == bad_burst && i == 4))
                            exp_data.push_back(mem_word(e.addr + AW'(i * STEP)));
                end
                s.addr = l_araddr; s.nb = early ? int'(l_arlen) : int'(l_arlen) + 1; s.num = ar_cnt - 1;
                sq.push_back(s);
            end
            if (l_arvalid && !l_arready) begin
                chk("arvalid_hold", axi.axi_arvalid, 1);
                chk("araddr_hold", axi.axi_araddr, l_araddr);
                chk("arlen_hold", axi.axi_arlen, l_arlen);
            end
            exp_wr = l_rvalid && l_rready && (l_rid == 4'd1);
            chk("wr_en", buf_wr_en, exp_wr);
            if (buf_wr_en) begin
                wr_cnt++;
                chk("wr_data_avail", exp_data.size() != 0, 1);
                if (exp_data.size() != 0) chk("wr_data", buf_wr_data, exp_data.pop_front());
            end
            if (l_rvalid && l_rready && sq.size() != 0) begin
                beat++;
                if (beat == sq[0].nb) begin sq.pop_front(); beat = 0; end
            end
            if (frame_done) begin
                done_cnt++;
                chk("busy_at_done", frame_busy, 0);
            end
            if (ar_hold > 0 && axi.axi_arvalid) begin
                axi.axi_arready = 1'b0; ar_hold--;
            end else
                axi.axi_arready = ar_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (sq.size() != 0 && !(gaps && $urandom_range(0, 2) == 0)) begin
                axi.axi_rvalid = 1'b1;
                axi.axi_rdata  = mem_word(sq[0].addr + AW'(beat * STEP));
                axi.axi_rlast  = (beat == sq[0].nb - 1);
                axi.axi_rid    = (sq[0].num == bad_burst && beat == 4) ? 4'd3 : 4'd1;
            end else begin
                axi.axi_rvalid = 1'b0; axi.axi_rlast = 1'b0;
            end
            l_arvalid = axi.axi_arvalid; l_arready = axi.axi_arready;
            l_araddr  = axi.axi_araddr;  l_arlen   = axi.axi_arlen;
            l_rvalid  = axi.axi_rvalid;  l_rready  = axi.axi_rready; l_rid = axi.axi_rid;
        end
    end

    task automatic start_frame(input logic [AW-1:0] base, input bit restart);
        if (restart) exp_ar.delete();
        model_frame(base);
        frame_base = base; frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int n = 0;
        while (done_cnt == d0 && n < 3000) begin @(negedge clk); n++; end
        chk("done_seen", done_cnt != d0, 1);
    endtask

    task automatic frame_end(input int d0, input int w0, input int exp_w, input logic exp_err);
        repeat (6) @(negedge clk);
        chk("done_count", done_cnt - d0, 1);
        chk("writes", wr_cnt - w0, exp_w);
        chk("ar_left", exp_ar.size(), 0);
        chk("data_left", exp_data.size(), 0);
        chk("rd_err", rd_err, exp_err);
        chk("busy_idle", frame_busy, 0);
    endtask

    task automatic full_frame(input logic [AW-1:0] base, input int exp_w, input logic exp_err);
        int d0 = done_cnt, w0 = wr_cnt;
        start_frame(base, 0);
        wait_done(d0);
        frame_end(d0, w0, exp_w, exp_err);
    endtask

    initial begin
        int d0, w0, a0, n;
        repeat (3) @(negedge clk);
        chk("rst_arvalid", axi.axi_arvalid, 0);
        chk("rst_rready", axi.axi_rready, 0);
        chk("rst_araddr", axi.axi_araddr, 0);
        chk("rst_arlen", axi.axi_arlen, 0);
        chk("rst_wr_en", buf_wr_en, 0);
        chk("rst_wr_data", buf_wr_data, 0);
        chk("rst_busy", frame_busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_rd_err", rd_err, 0);
        chk("arid", axi.axi_arid, 1);
        chk("arsize", axi.axi_arsize, 5);
        chk("arburst", axi.axi_arburst, 1);
        rst = 1'b1;

        frame_base = 28'h100; frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        repeat (10) @(negedge clk);
        chk("busy_no_init", frame_busy, 0);
        chk("arvalid_no_init", axi.axi_arvalid, 0);
        init_done = 1'b1;

        full_frame(28'h100, 40, 0);

        d0 = done_cnt; w0 = wr_cnt;
        buf_room = 1'b0;
        start_frame(28'h2000, 0);
        repeat (50) begin @(negedge clk); chk("arvalid_gated", axi.axi_arvalid, 0); end
        buf_room = 1'b1;
        @(negedge clk);
        chk("arvalid_rise", axi.axi_arvalid, 1);
        wait_done(d0);
        frame_end(d0, w0, 40, 0);

        ar_hold = 20; ar_rand = 1; gaps = 1;
        full_frame(28'h7_0000, 40, 0);

        d0 = done_cnt; w0 = wr_cnt; a0 = ar_cnt; n = 0;
        start_frame(28'h300, 0);
        while (ar_cnt < a0 + 2 && n < 1000) begin @(negedge clk); n++; end
        chk("second_burst", ar_cnt - a0, 2);
        start_frame(28'h4000, 1);
        wait_done(d0);
        frame_end(d0, w0, 72, 0);

        full_frame(28'hFFF_FFC0, 40, 0);
        for (int k = 0; k < 3; k++) full_frame(AW'($urandom), 40, 0);

        bad_burst = ar_cnt;
        full_frame(28'h50_0000, 39, 1);
        bad_burst = -1;
        full_frame(28'h60_0000, 40, 1);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rd_err_cleared", rd_err, 0);
        rst = 1'b1;
        @(negedge clk);

        early = 1;
        full_frame(AW'($urandom), 37, 1);
        early = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end
endmodule
